keygen_perm_stream: RTL
=======================

# keygen_perm_stream

Parametrised successor to the McEliece-style key generator. It computes the public key G' = S·G·P over GF(2) for run-time-loaded S (N_ROWS×N_ROWS), G (N_ROWS×K_COLS) and a permutation P. P is supplied as an index vector, not a dense K×K matrix, and is checked for validity. The block sits between the matrix sources (S/G/P generators) and the key store, and emits G' one column per valid/ready beat with back-pressure.

## Interface
Parameters:
- N_ROWS, 4, rows of G and S; width of each output column.
- K_COLS, 6, columns of G and G'; number of permutation entries.
- IDX_W, $clog2(K_COLS), width of a permutation index.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a key generation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- p_valid / p_ready  in / out  1 / 1  permutation index handshake.
- p_idx  in  IDX_W  perm[j] for j = 0..K_COLS-1 in order; P[perm[j]][j] = 1.
- s_valid / s_ready  in / out  1 / 1  S row handshake.
- s_row  in  N_ROWS  row i of S, bit c = S[i][c]; rows i = 0..N_ROWS-1 in order.
- g_valid / g_ready  in / out  1 / 1  G row handshake.
- g_row  in  K_COLS  row i of G, bit c = G[i][c].
- key_valid / key_ready  out / in  1 / 1  public-key column handshake.
- key_col  out  N_ROWS  column j of G'; bit i = G'[i][j].
- key_last  out  1  high with key_valid on column K_COLS-1.
- perm_err  out  1  invalid permutation detected; sticky until next accepted start.
- done  out  1  one-cycle pulse after the last column is accepted.

## Operation
- Beat accepted on valid && ready. Only the stream of the current state has ready high.
- State machine:
  - IDLE: start → LOAD_P. Clears perm_err, the seen bitmap and all counters.
  - LOAD_P: accept K_COLS indices into perm table. An index ≥ K_COLS, or one already present in the seen bitmap → ERR. After the K_COLS-th valid beat → LOAD_S.
  - LOAD_S: accept N_ROWS rows into the S buffer → LOAD_G.
  - LOAD_G: accept N_ROWS rows into the G buffer → MUL with j = 0, i = 0.
  - MUL: each cycle, key_col[i] ← XOR-reduce(s_buf[i] & gcol), where gcol bit r = g_buf[r][perm[j]]; i increments. After i = N_ROWS-1 → OUT.
  - OUT: key_valid = 1. On key_ready, either go to MUL with j+1 and i = 0, or, if j = K_COLS-1, go to DONE.
  - DONE: done = 1 for one cycle → IDLE.
  - ERR: perm_err = 1, all ready outputs low. start → LOAD_P (restart).
- start outside IDLE/ERR is ignored. Loads are not interruptible except by reset.
- GF(2) arithmetic only: AND for multiply, XOR for add. No carries; widths are exact.
- Buffers (perm table, S, G) are not cleared on reset; their content is don't-care until reloaded.

## Timing
- Reset values: busy, all readies, key_valid, key_last, perm_err, done = 0; key_col = 0; state IDLE.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. A partial key is discarded.
- start → LOAD_P readies high the following cycle.
- Load phase: minimum K_COLS + 2·N_ROWS cycles with valids held high.
- Per column: N_ROWS MUL cycles + ≥1 OUT cycle. Minimum total compute is K_COLS·(N_ROWS+1) cycles.
- key_col, key_valid, key_last are registered and stable while key_valid && !key_ready.
- perm_err rises the cycle after the offending beat. That beat is not written.
- done rises the cycle after the last column handshake.

## Structure
- Package keygen_pkg: state enum (IDLE, LOAD_P, LOAD_S, LOAD_G, MUL, OUT, DONE, ERR), default N_ROWS/K_COLS, IDX_W and counter-width functions.
- Sub-module gf2_dot: N-bit AND + XOR-reduce, reused for the row×column product.
- Top holds the FSM, counters (i, j, load count), seen bitmap and buffers.

## Test plan
All scenarios use N_ROWS = 4, K_COLS = 6.
- Identity S (rows 0001, 0010, 0100, 1000), perm 0..5, arbitrary G → column j of G' equals column j of G; key_last only on j = 5; done one cycle after.
- Identity S, perm 5,4,3,2,1,0 → G' columns are G columns in reverse order.
- S rows 0001, 0011, 0111, 1111, perm 0..5, G column 0 = 0101 → first key_col = 0011.
- Perm 0,1,1,… → perm_err = 1 after the third beat, p_ready = 0, no key_valid. Next start clears perm_err; a valid rerun then succeeds.
- key_ready low 5 cycles on column 2 → key_col/key_valid held stable; all 6 columns delivered in order, none lost or duplicated.
- reset asserted in MUL → all outputs 0 next cycle, busy = 0; a fresh start produces a correct full key.

Source files
------------

// File: rtl/keygen_perm_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keygen_pkg                                                                 |
// | Shared types, defaults and width helpers for the permuted key generator.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package keygen_pkg;

  localparam int c_N_ROWS_DEF = 4;
  localparam int c_K_COLS_DEF = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_P = 3'd1,
    LOAD_S = 3'd2,
    LOAD_G = 3'd3,
    MUL    = 3'd4,
    OUT    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  function automatic int idx_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keygen_perm_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keygen_perm_stream_if                                                      |
// | Valid/ready streams for P indices, S rows, G rows and public-key columns.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface keygen_perm_stream_if
  import keygen_pkg::*;
#(
  parameter int N_ROWS = c_N_ROWS_DEF,
  parameter int K_COLS = c_K_COLS_DEF,
  parameter int IDX_W  = idx_w(K_COLS)
);
  logic              p_valid;
  logic              p_ready;
  logic [IDX_W-1:0]  p_idx;
  logic              s_valid;
  logic              s_ready;
  logic [N_ROWS-1:0] s_row;
  logic              g_valid;
  logic              g_ready;
  logic [K_COLS-1:0] g_row;
  logic              key_valid;
  logic              key_ready;
  logic [N_ROWS-1:0] key_col;
  logic              key_last;

  modport slave (
    input  p_valid, p_idx, s_valid, s_row, g_valid, g_row, key_ready,
    output p_ready, s_ready, g_ready, key_valid, key_col, key_last
  );

  modport master (
    output p_valid, p_idx, s_valid, s_row, g_valid, g_row, key_ready,
    input  p_ready, s_ready, g_ready, key_valid, key_col, key_last
  );
endinterface
`default_nettype wire

// File: rtl/keygen_perm_stream_gf2_dot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf2_dot                                                                    |
// | GF(2) inner product: bitwise AND followed by XOR reduction.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gf2_dot #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_y
);
  assign o_y = ^(i_a & i_b);
endmodule
`default_nettype wire

// File: rtl/keygen_perm_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keygen_perm_stream                                                         |
// | Computes G' = S*G*P over GF(2), streaming one column of G' per beat.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keygen_perm_stream
  import keygen_pkg::*;
#(
  parameter int N_ROWS = c_N_ROWS_DEF,
  parameter int K_COLS = c_K_COLS_DEF,
  parameter int IDX_W  = idx_w(K_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      perm_err,
  output logic                      done,
  keygen_perm_stream_if.slave       bus
);

  localparam int                c_CW_I   = cnt_w(N_ROWS);
  localparam int                c_CW_J   = cnt_w(K_COLS);
  localparam logic [c_CW_I-1:0] c_I_LAST = c_CW_I'(N_ROWS - 1);
  localparam logic [c_CW_J-1:0] c_J_LAST = c_CW_J'(K_COLS - 1);
  localparam logic [IDX_W:0]    c_K_EXT  = (IDX_W + 1)'(K_COLS);

  state_t            r_state;
  state_t            w_next;
  logic [c_CW_I-1:0] r_i;
  logic [c_CW_J-1:0] r_j;
  logic [K_COLS-1:0] r_seen;
  logic [N_ROWS-1:0] r_key_col;
  logic [IDX_W-1:0]  r_perm  [K_COLS];
  logic [N_ROWS-1:0] r_s_buf [N_ROWS];
  logic [K_COLS-1:0] r_g_buf [N_ROWS];

  logic [N_ROWS-1:0] w_gcol;
  logic              w_dot;
  logic              w_i_last;
  logic              w_j_last;
  logic              w_idx_bad;
  logic              w_p_wr;
  logic              w_s_acc;
  logic              w_g_acc;

  assign w_i_last  = (r_i == c_I_LAST);
  assign w_j_last  = (r_j == c_J_LAST);
  // Range test first: out-of-range indices never reach the bitmap write.
  assign w_idx_bad = ({1'b0, bus.p_idx} >= c_K_EXT) || r_seen[bus.p_idx];
  assign w_p_wr    = (r_state == LOAD_P) && bus.p_valid && !w_idx_bad;
  assign w_s_acc   = (r_state == LOAD_S) && bus.s_valid;
  assign w_g_acc   = (r_state == LOAD_G) && bus.g_valid;

  assign busy          = (r_state != IDLE);
  assign perm_err      = (r_state == ERR);
  assign done          = (r_state == DONE);
  assign bus.p_ready   = (r_state == LOAD_P);
  assign bus.s_ready   = (r_state == LOAD_S);
  assign bus.g_ready   = (r_state == LOAD_G);
  assign bus.key_valid = (r_state == OUT);
  assign bus.key_last  = (r_state == OUT) && w_j_last;
  assign bus.key_col   = r_key_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = LOAD_P;
      LOAD_P: begin
        if (bus.p_valid) begin
          if (w_idx_bad)     w_next = ERR;
          else if (w_j_last) w_next = LOAD_S;
        end
      end
      LOAD_S: if (bus.s_valid && w_i_last) w_next = LOAD_G;
      LOAD_G: if (bus.g_valid && w_i_last) w_next = MUL;
      MUL:    if (w_i_last) w_next = OUT;
      OUT:    if (bus.key_ready) w_next = w_j_last ? DONE : MUL;
      DONE:   w_next = IDLE;
      ERR:    if (start) w_next = LOAD_P;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i       <= '0;
      r_j       <= '0;
      r_seen    <= '0;
      r_key_col <= '0;
    end else begin
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            r_i    <= '0;
            r_j    <= '0;
            r_seen <= '0;
          end
        end
        LOAD_P: begin
          if (w_p_wr) begin
            r_seen[bus.p_idx] <= 1'b1;
            r_j <= w_j_last ? '0 : r_j + 1'b1;
          end
        end
        LOAD_S: if (w_s_acc) r_i <= w_i_last ? '0 : r_i + 1'b1;
        LOAD_G: if (w_g_acc) r_i <= w_i_last ? '0 : r_i + 1'b1;
        MUL: begin
          r_key_col[r_i] <= w_dot;
          r_i <= w_i_last ? '0 : r_i + 1'b1;
        end
        OUT: begin
          if (bus.key_ready) begin
            r_i <= '0;
            r_j <= w_j_last ? '0 : r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix buffers hold no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (w_p_wr)  r_perm[r_j]  <= bus.p_idx;
    if (w_s_acc) r_s_buf[r_i] <= bus.s_row;
    if (w_g_acc) r_g_buf[r_i] <= bus.g_row;
  end

  always_comb begin
    w_gcol = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      w_gcol[r] = r_g_buf[r][r_perm[r_j]];
    end
  end

  gf2_dot #(.W(N_ROWS)) u_dot (
    .i_a (r_s_buf[r_i]),
    .i_b (w_gcol),
    .o_y (w_dot)
  );

endmodule
`default_nettype wire
